// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and grant encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a conflict the requester not named by last_grant wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  gnt_t       last_grant,
    output logic [1:0] gnt
);

    // gnt[0] selects the instruction side, gnt[1] the data side.
    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d) begin
            gnt = (last_grant == GNT_I) ? 2'b10 : 2'b01;
        end else if (req_i) begin
            gnt = 2'b01;
        end else if (req_d) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch and a data requester,
// with round-robin conflict resolution and a bounded wait for the memory acknowledge.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_dout,
    output logic                  i_stall,
    output logic                  i_ack,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_din,
    output logic [31:0]           d_dout,
    output logic                  d_stall,
    output logic                  d_ack,
    output logic                  mem_cs,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout,
    input  logic                  mem_ack,
    output logic                  err
);

    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = TIMEOUT[WAIT_W-1:0];

    state_t                state;
    gnt_t                  last_grant;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [31:0]           txn_din;
    logic                  txn_ren;
    logic                  txn_wen;
    logic [31:0]           i_dout_q;
    logic [31:0]           d_dout_q;
    logic                  d_req;
    logic                  busy;
    logic [1:0]            gnt;

    assign d_req = d_ren | d_wen;

    rr_arb2 u_rr_arb2 (
        .req_i      (i_ren),
        .req_d      (d_req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // The memory bus is only driven from the transaction register while in flight and out of reset.
    assign busy     = (state != IDLE) && !rst;
    assign mem_cs   = busy;
    assign mem_ren  = busy && txn_ren;
    assign mem_wen  = busy && txn_wen;
    assign mem_addr = busy ? txn_addr : '0;
    assign mem_din  = busy ? txn_din : '0;

    // A requester that withdrew mid-transaction gets no acknowledge.
    assign i_ack   = !rst && (state == BUSY_I) && mem_ack && i_ren;
    assign d_ack   = !rst && (state == BUSY_D) && mem_ack && d_req;
    assign i_stall = i_ren && !i_ack;
    assign d_stall = d_req && !d_ack;
    assign i_dout  = i_ack ? mem_dout : i_dout_q;
    assign d_dout  = d_ack ? mem_dout : d_dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            wait_cnt   <= '0;
            txn_addr   <= '0;
            txn_din    <= '0;
            txn_ren    <= 1'b0;
            txn_wen    <= 1'b0;
            i_dout_q   <= '0;
            d_dout_q   <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (i_ack) i_dout_q <= mem_dout;
            if (d_ack) d_dout_q <= mem_dout;
            case (state)
                IDLE: begin
                    if (gnt[1]) begin
                        state      <= BUSY_D;
                        last_grant <= GNT_D;
                        wait_cnt   <= '0;
                        txn_addr   <= d_addr;
                        txn_din    <= d_din;
                        txn_ren    <= d_ren;
                        txn_wen    <= d_wen;
                    end else if (gnt[0]) begin
                        state      <= BUSY_I;
                        last_grant <= GNT_I;
                        wait_cnt   <= '0;
                        txn_addr   <= i_addr;
                        txn_din    <= '0;
                        txn_ren    <= 1'b1;
                        txn_wen    <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end else if (wait_cnt == TIMEOUT_LIM - 1'b1) begin
                        // Give up: the requester is still pending and will be re-arbitrated.
                        state    <= IDLE;
                        err      <= 1'b1;
                        wait_cnt <= TIMEOUT_LIM;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a rule-based model.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_ren = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_dout;
    logic          i_stall;
    logic          i_ack;
    logic          d_ren = 1'b0;
    logic          d_wen = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_din = '0;
    logic [31:0]   d_dout;
    logic          d_stall;
    logic          d_ack;
    logic          mem_cs;
    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = '0;
    logic          mem_ack = 1'b0;
    logic          err;

    int          total = 0;
    int          bad = 0;
    logic        rand_lat = 1'b0;
    logic        idle_noise = 1'b0;
    logic        force_ack = 1'b0;
    int          fixed_lat = 1;
    int          busy_cnt = 0;
    int          cur_lat = 1;
    logic [31:0] last_d_dout = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_addr(i_addr), .i_dout(i_dout), .i_stall(i_stall), .i_ack(i_ack),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_stall(d_stall), .d_ack(d_ack),
        .mem_cs(mem_cs), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: acks on the cur_lat-th cycle of mem_cs (0 = never), fresh read data every cycle.
    always @(posedge clk) begin
        #2;
        if (mem_cs) busy_cnt++; else busy_cnt = 0;
        if (busy_cnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 6)) : fixed_lat;
        mem_dout = $urandom;
        mem_ack  = force_ack || (mem_cs && cur_lat != 0 && busy_cnt == cur_lat)
                   || (!mem_cs && idle_noise && ($urandom_range(0, 3) == 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        last_d_dout = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_ren = 1'b1; i_addr = 32'h44; d_ren = 1'b0; d_wen = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL reset_mem_cs got=%b want=0", mem_cs); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if ({mem_ren, mem_wen} !== 2'b00) begin bad++; $display("FAIL reset_mem_op got=%b want=00", {mem_ren, mem_wen}); end
        total++; if (mem_din !== '0) begin bad++; $display("FAIL reset_mem_din got=%h want=0", mem_din); end
        total++; if ({i_ack, d_ack, err} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b want=000", {i_ack, d_ack, err}); end
        total++; if (i_dout !== '0 || d_dout !== '0) begin bad++; $display("FAIL reset_dout got=%h/%h want=0/0", i_dout, d_dout); end
        total++; if (i_stall !== 1'b1) begin bad++; $display("FAIL reset_i_stall got=%b want=1", i_stall); end
        tick();
        rst = 1'b0; i_ren = 1'b0;
        @(negedge clk);
        total++; if (mem_cs !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_reset_idle got cs=%b err=%b want 0 0", mem_cs, err); end
    endtask

    task automatic test_single_read();
        logic [31:0] captured;
        captured  = '0;
        fixed_lat = 2;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin i_ren = 1'b1; i_addr = 32'h10; end
            if (c == 3) i_ren = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                total++; if (mem_cs !== 1'b0 || i_stall !== 1'b1) begin bad++; $display("FAIL rd_c0 got cs=%b stall=%b want 0 1", mem_cs, i_stall); end
            end
            if (c == 1) begin
                total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL rd_c1_bus got cs=%b addr=%h want 1 10", mem_cs, mem_addr); end
                total++; if ({mem_ren, mem_wen, i_ack} !== 3'b100) begin bad++; $display("FAIL rd_c1_op got=%b want=100", {mem_ren, mem_wen, i_ack}); end
            end
            if (c == 2) begin
                captured = mem_dout;
                total++; if (i_ack !== 1'b1 || i_stall !== 1'b0) begin bad++; $display("FAIL rd_c2_ack got ack=%b stall=%b want 1 0", i_ack, i_stall); end
                total++; if (i_dout !== captured) begin bad++; $display("FAIL rd_c2_dout got=%h want=%h", i_dout, captured); end
                total++; if (d_ack !== 1'b0 || d_dout !== '0) begin bad++; $display("FAIL rd_d_side got ack=%b dout=%h want 0 0", d_ack, d_dout); end
            end
            if (c == 4) begin
                total++; if (mem_cs !== 1'b0 || i_dout !== captured) begin bad++; $display("FAIL rd_hold got cs=%b dout=%h want 0 %h", mem_cs, i_dout, captured); end
            end
        end
    endtask

    task automatic test_conflict();
        int   order[$];
        logic prev_cs;
        prev_cs   = 1'b0;
        fixed_lat = 1;
        apply_reset();
        i_ren = 1'b1; i_addr = 32'h100; d_ren = 1'b1; d_addr = 32'h200;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk);
            if (mem_cs && !prev_cs) order.push_back((mem_addr == 32'h200) ? 1 : 0);
            if (mem_cs && mem_addr == 32'h100) begin
                total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL cf_d_stall got=%b want=1", d_stall); end
            end
            if (mem_cs && mem_addr == 32'h200) begin
                total++; if (i_stall !== 1'b1) begin bad++; $display("FAIL cf_i_stall got=%b want=1", i_stall); end
            end
            prev_cs = mem_cs;
            tick();
        end
        total++; if (order.size() != 6) begin bad++; $display("FAIL cf_count got=%0d want=6", order.size()); end
        foreach (order[k]) begin
            total++; if (order[k] != ((k % 2 == 0) ? 1 : 0)) begin bad++; $display("FAIL cf_order k=%0d got=%0d want=%0d (1=D)", k, order[k], (k % 2 == 0) ? 1 : 0); end
        end
        i_ren = 1'b0; d_ren = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write();
        int acks = 0;
        int busy = 0;
        int iacks = 0;
        fixed_lat = 3;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) begin d_wen = 1'b1; d_addr = 32'h20; d_din = 32'hDEADBEEF; end
            else if (acks > 0) d_wen = 1'b0;
            @(negedge clk);
            if (mem_cs) begin
                busy++;
                total++; if ({mem_wen, mem_ren} !== 2'b10) begin bad++; $display("FAIL wr_op got=%b want=10", {mem_wen, mem_ren}); end
                total++; if (mem_addr !== 32'h20 || mem_din !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_bus got=%h/%h want=20/deadbeef", mem_addr, mem_din); end
                if (!d_ack) begin
                    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL wr_stall got=%b want=1", d_stall); end
                end
            end
            if (d_ack) begin
                acks++;
                last_d_dout = mem_dout;
                total++; if (d_dout !== last_d_dout) begin bad++; $display("FAIL wr_dout got=%h want=%h", d_dout, last_d_dout); end
            end
            if (i_ack) iacks++;
        end
        total++; if (acks != 1 || iacks != 0) begin bad++; $display("FAIL wr_ack_count got d=%0d i=%0d want 1 0", acks, iacks); end
        total++; if (busy != 3) begin bad++; $display("FAIL wr_busy_cycles got=%0d want=3", busy); end
        total++; if (mem_cs !== 1'b0 || d_stall !== 1'b0) begin bad++; $display("FAIL wr_end got cs=%b stall=%b want 0 0", mem_cs, d_stall); end
    endtask

    task automatic test_timeout();
        int busy = 0;
        int err_cnt = 0;
        int err_cyc = -1;
        int busy_at_err = -1;
        int ack_cnt = 0;
        int ack_cyc = -1;
        fixed_lat = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 0) begin i_ren = 1'b1; i_addr = 32'h40; end
            else if (ack_cnt > 0) i_ren = 1'b0;
            @(negedge clk);
            if (mem_cs) busy++;
            if (i_ack) begin ack_cnt++; ack_cyc = c; end
            if (err) begin
                err_cnt++; err_cyc = c; busy_at_err = busy; fixed_lat = 1;
                total++; if (mem_cs !== 1'b0 || i_ack !== 1'b0) begin bad++; $display("FAIL to_err_cycle got cs=%b ack=%b want 0 0", mem_cs, i_ack); end
            end
        end
        total++; if (err_cnt != 1) begin bad++; $display("FAIL to_err_count got=%0d want=1", err_cnt); end
        total++; if (busy_at_err != TMO || err_cyc != 5) begin bad++; $display("FAIL to_err_timing got busy=%0d cyc=%0d want %0d 5", busy_at_err, err_cyc, TMO); end
        total++; if (ack_cnt != 1 || ack_cyc != 6) begin bad++; $display("FAIL to_rearb got acks=%0d cyc=%0d want 1 6", ack_cnt, ack_cyc); end
    endtask

    task automatic test_drop();
        int busy = 0;
        int acks = 0;
        int mem_acks = 0;
        int errs = 0;
        fixed_lat = 4;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) begin d_ren = 1'b1; d_addr = 32'h30; end
            if (c == 1) d_ren = 1'b0;
            @(negedge clk);
            if (mem_cs) begin
                busy++;
                if (mem_ack) mem_acks++;
                total++; if (mem_addr !== 32'h30 || mem_ren !== 1'b1) begin bad++; $display("FAIL drop_hold got addr=%h ren=%b want 30 1", mem_addr, mem_ren); end
            end
            if (d_ack) acks++;
            if (err) errs++;
            if (c >= 1) begin
                total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL drop_stall got=%b want=0", d_stall); end
            end
        end
        total++; if (busy != 4 || mem_acks != 1) begin bad++; $display("FAIL drop_busy got busy=%0d macks=%0d want 4 1", busy, mem_acks); end
        total++; if (acks != 0 || errs != 0) begin bad++; $display("FAIL drop_ack got acks=%0d errs=%0d want 0 0", acks, errs); end
        total++; if (mem_cs !== 1'b0 || d_dout !== last_d_dout) begin bad++; $display("FAIL drop_end got cs=%b dout=%h want 0 %h", mem_cs, d_dout, last_d_dout); end
    endtask

    task automatic test_reset_busy();
        fixed_lat = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            case (c)
                0: begin i_ren = 1'b1; i_addr = 32'h50; end
                2: begin rst = 1'b1; force_ack = 1'b1; end
                3: begin rst = 1'b0; force_ack = 1'b0; i_ren = 1'b0; end
                4: begin i_ren = 1'b1; i_addr = 32'h100; d_ren = 1'b1; d_addr = 32'h200; fixed_lat = 1; end
                6: d_ren = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (c == 1) begin
                total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h50) begin bad++; $display("FAIL rb_busy got cs=%b addr=%h want 1 50", mem_cs, mem_addr); end
            end
            if (c == 2) begin
                total++; if (mem_cs !== 1'b0 || mem_addr !== '0 || i_ack !== 1'b0) begin bad++; $display("FAIL rb_in_reset got cs=%b addr=%h ack=%b want 0 0 0", mem_cs, mem_addr, i_ack); end
            end
            if (c == 3) begin
                total++; if (mem_cs !== 1'b0 || i_ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rb_idle got cs=%b ack=%b err=%b want 0 0 0", mem_cs, i_ack, err); end
                total++; if (i_dout !== '0 || d_dout !== '0) begin bad++; $display("FAIL rb_dout got=%h/%h want 0/0", i_dout, d_dout); end
            end
            if (c == 5) begin
                total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h200 || d_ack !== 1'b1) begin bad++; $display("FAIL rb_last_grant got cs=%b addr=%h dack=%b want 1 200 1", mem_cs, mem_addr, d_ack); end
            end
            if (c == 7) begin
                total++; if (mem_addr !== 32'h100 || i_ack !== 1'b1) begin bad++; $display("FAIL rb_then_i got addr=%h ack=%b want 100 1", mem_addr, i_ack); end
            end
        end
        i_ren = 1'b0; d_ren = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic        p_cs, p_ack, p_ireq, p_dreq, p_dren, p_dwen;
        logic [31:0] p_iaddr, p_daddr, p_ddin;
        logic        m_last, owner, e_cs, e_err, x_iack, x_dack, i_done, d_done;
        logic [65:0] e_txn, e_bus;
        logic [31:0] e_idout, e_ddout;
        int          run;
        apply_reset();
        rand_lat = 1'b1; idle_noise = 1'b1;
        p_cs = 1'b0; p_ack = 1'b0; p_ireq = 1'b0; p_dreq = 1'b0; p_dren = 1'b0; p_dwen = 1'b0;
        p_iaddr = '0; p_daddr = '0; p_ddin = '0;
        m_last = 1'b0; owner = 1'b0; i_done = 1'b0; d_done = 1'b0;
        e_txn = '0; e_idout = '0; e_ddout = '0; run = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) tick();
            // Requesters hold until acked, then either drop or issue a new request at once.
            if ((i_ren && i_done && $urandom_range(0, 1) == 0) || (!i_ren && $urandom_range(0, 2) == 0)) begin
                i_ren = 1'b1; i_addr = 32'h100 + 32'($urandom_range(0, 255));
            end else if (i_done) i_ren = 1'b0;
            if ((d_ren | d_wen) && d_done && $urandom_range(0, 1) == 0 || (!(d_ren | d_wen) && $urandom_range(0, 2) == 0)) begin
                d_wen = ($urandom_range(0, 1) == 1); d_ren = !d_wen;
                d_addr = 32'h200 + 32'($urandom_range(0, 255)); d_din = $urandom;
            end else if (d_done) begin d_ren = 1'b0; d_wen = 1'b0; end
            @(negedge clk);
            e_cs  = p_cs ? !(p_ack || run == TMO) : (p_ireq || p_dreq);
            e_err = p_cs && !p_ack && run == TMO;
            if (mem_cs && !p_cs) begin
                owner  = (p_ireq && p_dreq) ? !m_last : p_dreq;
                m_last = owner;
                e_txn  = owner ? {p_daddr, p_ddin, p_dren, p_dwen} : {p_iaddr, 32'h0, 1'b1, 1'b0};
            end
            if (mem_cs) run++; else run = 0;
            e_bus  = mem_cs ? e_txn : '0;
            x_iack = mem_cs && mem_ack && !owner;
            x_dack = mem_cs && mem_ack && owner;
            if (x_iack) e_idout = mem_dout;
            if (x_dack) e_ddout = mem_dout;
            total++; if (mem_cs !== e_cs) begin bad++; $display("FAIL rnd_cs c=%0d got=%b want=%b", c, mem_cs, e_cs); end
            total++; if (err !== e_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err, e_err); end
            total++; if ({mem_addr, mem_din, mem_ren, mem_wen} !== e_bus) begin bad++; $display("FAIL rnd_bus c=%0d got=%h want=%h", c, {mem_addr, mem_din, mem_ren, mem_wen}, e_bus); end
            total++; if ({i_ack, d_ack} !== {x_iack, x_dack}) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, {i_ack, d_ack}, {x_iack, x_dack}); end
            total++; if (i_dout !== e_idout || d_dout !== e_ddout) begin bad++; $display("FAIL rnd_dout c=%0d got=%h/%h want=%h/%h", c, i_dout, d_dout, e_idout, e_ddout); end
            total++; if ({i_stall, d_stall} !== {i_ren && !x_iack, (d_ren || d_wen) && !x_dack}) begin bad++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, {i_stall, d_stall}, {i_ren && !x_iack, (d_ren || d_wen) && !x_dack}); end
            i_done = x_iack; d_done = x_dack;
            p_cs = mem_cs; p_ack = mem_ack; p_ireq = i_ren; p_iaddr = i_addr;
            p_dreq = d_ren || d_wen; p_dren = d_ren; p_dwen = d_wen; p_daddr = d_addr; p_ddin = d_din;
        end
        rand_lat = 1'b0; idle_noise = 1'b0;
        i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_drop();
        test_timeout();
        test_conflict();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
